// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache: FSM states and the access-size encoding
// used by the decoder's DMem_size field.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} dcache_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int LANES = 4;

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane steering for the data cache: store byte enables and lane-shifted
// store data, plus load lane selection with sign/zero extension.
module dcache_lane_align
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] st_data,
    input  logic [WIDTH-1:0] ld_word,
    output logic [3:0]       st_be,
    output logic [WIDTH-1:0] st_lanes,
    output logic [WIDTH-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misaligned halves drop addr[0]; words ignore both low bits.
    assign ld_byte = ld_word[8*addr_lo +: 8];
    assign ld_half = ld_word[16*addr_lo[1] +: 16];

    always_comb begin
        st_be    = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_word;
        case (size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << addr_lo;
                st_lanes = {{(WIDTH-8){1'b0}}, st_data[7:0]} << {addr_lo, 3'b000};
                ld_data  = {{(WIDTH-8){~is_unsigned & ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {{(WIDTH-16){1'b0}}, st_data[15:0]} << {addr_lo[1], 4'b0000};
                ld_data  = {{(WIDTH-16){~is_unsigned & ld_half[15]}}, ld_half};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one word
// per line. Load hits are served combinationally; misses and stores stall.
module data_cache
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_size,
    input  logic             cpu_unsigned,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - 2 - IDX_W;

    dcache_state_t    state_q, state_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [WIDTH-3:0] waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;

    logic [TAG_W-1:0] tag_mem [SETS];

    logic [IDX_W-1:0] cpu_idx, req_idx;
    logic [TAG_W-1:0] cpu_tag, req_tag;
    logic             cpu_hit, req_hit;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] wr_word;
    logic [3:0]       lane_we;
    logic             tag_we;

    logic [3:0]       st_be;
    logic [WIDTH-1:0] st_lanes;
    logic [WIDTH-1:0] ld_data;

    assign cpu_idx = cpu_addr[2 +: IDX_W];
    assign cpu_tag = cpu_addr[WIDTH-1 -: TAG_W];
    assign req_idx = waddr_q[IDX_W-1:0];
    assign req_tag = waddr_q[WIDTH-3 -: TAG_W];

    assign cpu_hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // One narrow array per byte lane so stores merge only their enabled bytes.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [SETS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[req_idx] <= wr_word[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[cpu_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    dcache_lane_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .size        (cpu_size),
        .is_unsigned (cpu_unsigned),
        .addr_lo     (cpu_addr[1:0]),
        .st_data     (cpu_wdata),
        .ld_word     (rd_word),
        .st_be       (st_be),
        .st_lanes    (st_lanes),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        stall     = 1'b0;
        cpu_rdata = '0;
        tag_we    = 1'b0;
        lane_we   = 4'b0000;
        wr_word   = mem_rdata;
        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    stall   = 1'b1;
                    state_d = WRITE;
                    waddr_d = cpu_addr[WIDTH-1:2];
                    wdata_d = st_lanes;
                    be_d    = st_be;
                end else if (cpu_re) begin
                    if (cpu_hit) begin
                        cpu_rdata = ld_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = REFILL;
                        waddr_d = cpu_addr[WIDTH-1:2];
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    valid_d[req_idx] = 1'b1;
                    tag_we           = 1'b1;
                    lane_we          = 4'b1111;
                    state_d          = IDLE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ack) begin
                    // Write-through without allocate: only a resident line is updated.
                    if (req_hit) begin
                        lane_we = be_q;
                    end
                    wr_word = wdata_q;
                    state_d = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Request outputs come straight from registered state so they hold steady until ack.
    assign mem_req   = (state_q == REFILL) || (state_q == WRITE);
    assign mem_we    = (state_q == WRITE);
    assign mem_be    = (state_q == WRITE)  ? be_q :
                       (state_q == REFILL) ? 4'b1111 : 4'b0000;
    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_wdata = wdata_q;

endmodule
